// File: rtl/rf_wr_arbiter.sv
// Register-file write-port arbiter: the in-order pipeline writeback has priority, and
// long-latency async results are queued, killed when stale, and forced through on starvation.
module rf_wr_arbiter #(
  parameter int DEPTH        = 2,
  parameter int STARVE_LIMIT = 4
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     i_pipe_RegWrEn,
  input  logic [4:0]               i_pipe_RegDst,
  input  logic [31:0]              i_pipe_RegWrData,
  input  logic                     i_async_valid,
  output logic                     o_async_ready,
  input  logic [4:0]               i_async_RegDst,
  input  logic [31:0]              i_async_Data,
  output logic                     o_RegWrEn,
  output logic [4:0]               o_RegDst,
  output logic [31:0]              o_RegWrData,
  output logic                     o_pipe_stall,
  output logic [$clog2(DEPTH):0]   o_pending_cnt,
  input  logic [4:0]               i_rs1,
  input  logic [4:0]               i_rs2,
  output logic                     o_rs1_pending,
  output logic                     o_rs2_pending
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;
  localparam int WW = $clog2(STARVE_LIMIT + 1);

  logic [4:0]       rd_q   [DEPTH];
  logic [31:0]      data_q [DEPTH];
  logic [DEPTH-1:0] live_q;
  logic [DEPTH-1:0] live_nxt;
  logic [DEPTH-1:0] kill_vec;
  logic [PW-1:0]    wr_ptr;
  logic [PW-1:0]    rd_ptr;
  logic [CW-1:0]    count;
  logic [WW-1:0]    wait_cnt;
  logic             stall_q;

  logic head_valid;
  logic head_live;
  logic pipe_act;
  logic grant;
  logic pop;
  logic ready;
  logic push;
  logic store;
  logic push_live;
  logic blocked;
  logic starve_hit;

  always_comb begin
    head_valid = (count != '0);
    head_live  = head_valid & live_q[rd_ptr];
    pipe_act   = !reset & i_pipe_RegWrEn & (i_pipe_RegDst != 5'd0) & !stall_q;
    grant      = !reset & head_live & !pipe_act;
    // A dead head drains every cycle; a live head leaves only when it gets the port.
    pop        = !reset & head_valid & (!live_q[rd_ptr] | !pipe_act);
    ready      = !reset & (count < CW'(DEPTH));
    push       = i_async_valid & ready;
    store      = push & (i_async_RegDst != 5'd0);
    push_live  = !(pipe_act & (i_async_RegDst == i_pipe_RegDst));
    blocked    = head_live & pipe_act;
    starve_hit = blocked & (wait_cnt == WW'(STARVE_LIMIT - 1));
  end

  always_comb begin
    o_RegWrEn   = 1'b0;
    o_RegDst    = '0;
    o_RegWrData = '0;
    if (pipe_act) begin
      o_RegWrEn   = 1'b1;
      o_RegDst    = i_pipe_RegDst;
      o_RegWrData = i_pipe_RegWrData;
    end else if (grant) begin
      o_RegWrEn   = 1'b1;
      o_RegDst    = rd_q[rd_ptr];
      o_RegWrData = data_q[rd_ptr];
    end
  end

  // A live bit is only ever set on an occupied slot and cleared on pop, so it also marks occupancy.
  always_comb begin
    for (int unsigned i = 0; i < DEPTH; i++) begin
      kill_vec[i] = pipe_act & live_q[i] & (rd_q[i] == i_pipe_RegDst);
      live_nxt[i] = live_q[i] & !kill_vec[i];
      if (pop && (rd_ptr == PW'(i)))
        live_nxt[i] = 1'b0;
      if (store && (wr_ptr == PW'(i)))
        live_nxt[i] = push_live;
    end
  end

  always_comb begin
    o_rs1_pending = 1'b0;
    o_rs2_pending = 1'b0;
    for (int unsigned i = 0; i < DEPTH; i++) begin
      if (live_q[i] && (rd_q[i] == i_rs1))
        o_rs1_pending = 1'b1;
      if (live_q[i] && (rd_q[i] == i_rs2))
        o_rs2_pending = 1'b1;
    end
    if (reset || (i_rs1 == 5'd0))
      o_rs1_pending = 1'b0;
    if (reset || (i_rs2 == 5'd0))
      o_rs2_pending = 1'b0;
  end

  always_ff @(posedge clk) begin
    if (store) begin
      rd_q[wr_ptr]   <= i_async_RegDst;
      data_q[wr_ptr] <= i_async_Data;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      live_q   <= '0;
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      count    <= '0;
      wait_cnt <= '0;
      stall_q  <= 1'b0;
    end else begin
      live_q <= live_nxt;
      if (store)
        wr_ptr <= wr_ptr + PW'(1);
      if (pop)
        rd_ptr <= rd_ptr + PW'(1);
      case ({store, pop})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
      wait_cnt <= blocked ? wait_cnt + WW'(1) : '0;
      stall_q  <= starve_hit;
    end
  end

  assign o_async_ready = ready;
  assign o_pipe_stall  = stall_q;
  assign o_pending_cnt = reset ? '0 : count;

endmodule

// File: tb/tb_rf_wr_arbiter.sv
// Scoreboard bench for rf_wr_arbiter: a queue-level reference model predicts each cycle's
// status and every register-file write; a negedge monitor pops and compares.
module tb_rf_wr_arbiter;

  localparam int DEPTH = 2;
  localparam int LIMIT = 4;
  localparam int CW    = $clog2(DEPTH) + 1;

  logic          clk = 1'b0;
  logic          reset;
  logic          i_pipe_RegWrEn;
  logic [4:0]    i_pipe_RegDst;
  logic [31:0]   i_pipe_RegWrData;
  logic          i_async_valid;
  logic          o_async_ready;
  logic [4:0]    i_async_RegDst;
  logic [31:0]   i_async_Data;
  logic          o_RegWrEn;
  logic [4:0]    o_RegDst;
  logic [31:0]   o_RegWrData;
  logic          o_pipe_stall;
  logic [CW-1:0] o_pending_cnt;
  logic [4:0]    i_rs1;
  logic [4:0]    i_rs2;
  logic          o_rs1_pending;
  logic          o_rs2_pending;

  always #5 clk = ~clk;

  rf_wr_arbiter #(.DEPTH(DEPTH), .STARVE_LIMIT(LIMIT)) dut (
    .clk(clk), .reset(reset),
    .i_pipe_RegWrEn(i_pipe_RegWrEn), .i_pipe_RegDst(i_pipe_RegDst),
    .i_pipe_RegWrData(i_pipe_RegWrData),
    .i_async_valid(i_async_valid), .o_async_ready(o_async_ready),
    .i_async_RegDst(i_async_RegDst), .i_async_Data(i_async_Data),
    .o_RegWrEn(o_RegWrEn), .o_RegDst(o_RegDst), .o_RegWrData(o_RegWrData),
    .o_pipe_stall(o_pipe_stall), .o_pending_cnt(o_pending_cnt),
    .i_rs1(i_rs1), .i_rs2(i_rs2),
    .o_rs1_pending(o_rs1_pending), .o_rs2_pending(o_rs2_pending)
  );

  typedef struct {
    logic [4:0]  rd;
    logic [31:0] data;
    bit          live;
  } ent_t;

  typedef struct {
    logic [4:0]  rd;
    logic [31:0] data;
  } wr_t;

  typedef struct {
    bit ready;
    bit stall;
    bit wren;
    bit p1;
    bit p2;
    int cnt;
  } st_t;

  ent_t mq[$];
  bit   m_stall = 1'b0;
  int   m_wait  = 0;
  bit   m_acc;

  wr_t  exp_wr[$];
  st_t  exp_st[$];

  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s actual=%h required=%h at %0t", name, act, req, $time);
    end
  endtask

  function automatic bit pend(input logic [4:0] r);
    if (r == 5'd0) return 1'b0;
    foreach (mq[i]) if (mq[i].live && mq[i].rd == r) return 1'b1;
    return 1'b0;
  endfunction

  // Drive one cycle's inputs and advance the reference model over that cycle.
  task automatic step(input bit rst, input bit we, input logic [4:0] dst, input logic [31:0] wd,
                      input bit av, input logic [4:0] ard, input logic [31:0] ad,
                      input logic [4:0] r1, input logic [4:0] r2);
    st_t e;
    wr_t w;
    bit  pa, hl, rdy, blk;
    @(posedge clk);
    #1;
    reset = rst; i_pipe_RegWrEn = we; i_pipe_RegDst = dst; i_pipe_RegWrData = wd;
    i_async_valid = av; i_async_RegDst = ard; i_async_Data = ad; i_rs1 = r1; i_rs2 = r2;
    m_acc = 1'b0;
    e.stall = m_stall;
    if (rst) begin
      e.ready = 0; e.wren = 0; e.p1 = 0; e.p2 = 0; e.cnt = 0;
      exp_st.push_back(e);
      mq.delete();
      m_stall = 1'b0;
      m_wait  = 0;
      return;
    end
    pa  = we && dst != 5'd0 && !m_stall;
    hl  = mq.size() > 0 && mq[0].live;
    rdy = mq.size() < DEPTH;
    e.ready = rdy;
    e.cnt   = mq.size();
    e.p1    = pend(r1);
    e.p2    = pend(r2);
    e.wren  = pa || hl;
    if (pa) begin
      w.rd = dst; w.data = wd; exp_wr.push_back(w);
    end else if (hl) begin
      w.rd = mq[0].rd; w.data = mq[0].data; exp_wr.push_back(w);
    end
    exp_st.push_back(e);
    blk = hl && pa;
    m_stall = blk && (m_wait == LIMIT - 1);
    m_wait  = blk ? m_wait + 1 : 0;
    if (mq.size() > 0 && (!mq[0].live || !pa)) void'(mq.pop_front());
    if (pa) foreach (mq[i]) if (mq[i].rd == dst) mq[i].live = 1'b0;
    if (av && rdy) begin
      m_acc = 1'b1;
      if (ard != 5'd0) mq.push_back('{rd: ard, data: ad, live: !(pa && ard == dst)});
    end
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(0, 0, 0, 0, 0, 0, 0, 0, 0);
  endtask

  always @(negedge clk) begin
    if (exp_st.size() > 0) begin
      st_t e;
      e = exp_st.pop_front();
      chk("async_ready", 32'(o_async_ready), 32'(e.ready));
      chk("pipe_stall", 32'(o_pipe_stall), 32'(e.stall));
      chk("pending_cnt", 32'(o_pending_cnt), 32'(e.cnt));
      chk("rs1_pending", 32'(o_rs1_pending), 32'(e.p1));
      chk("rs2_pending", 32'(o_rs2_pending), 32'(e.p2));
      chk("RegWrEn", 32'(o_RegWrEn), 32'(e.wren));
      if (o_RegWrEn) begin
        if (exp_wr.size() == 0) begin
          chk("unexpected_write_rd", 32'(o_RegDst), 32'hFFFF_FFFF);
        end else begin
          wr_t w;
          w = exp_wr.pop_front();
          chk("write_rd", 32'(o_RegDst), 32'(w.rd));
          chk("write_data", o_RegWrData, w.data);
        end
      end else if (e.wren && exp_wr.size() > 0) begin
        void'(exp_wr.pop_front());
      end
    end
  end

  initial begin
    int n;
    reset = 1'b1; i_pipe_RegWrEn = 0; i_pipe_RegDst = 0; i_pipe_RegWrData = 0;
    i_async_valid = 0; i_async_RegDst = 0; i_async_Data = 0; i_rs1 = 0; i_rs2 = 0;
    repeat (2) @(posedge clk);
    step(1, 0, 0, 0, 0, 0, 0, 0, 0);

    // Idle pipe: async write appears one cycle after the push, then queue is empty.
    step(0, 0, 0, 0, 1, 5'd5, 32'hA5, 5'd5, 0);
    idle(3);

    // Busy pipe starves the async head until a forced stall.
    step(0, 1, 5'd3, 32'h33, 1, 5'd7, 32'h77, 5'd7, 5'd3);
    for (int i = 0; i < 7; i++) step(0, 1, 5'd3, 32'h33, 0, 0, 0, 5'd7, 5'd3);
    idle(2);

    // Younger pipe write to the same register kills the queued async write.
    step(0, 1, 5'd4, 32'h44, 1, 5'd9, 32'h99, 5'd9, 0);
    step(0, 1, 5'd4, 32'h44, 0, 0, 0, 5'd9, 0);
    step(0, 1, 5'd9, 32'h11, 0, 0, 0, 5'd9, 0);
    idle(3);

    // Three back-to-back pushes against a busy pipe; the third waits for room.
    for (int k = 0; k < 3; k++) begin
      n = 0;
      m_acc = 1'b0;
      while (!m_acc && n < 20) begin
        step(0, 1, 5'd2, 32'h22, 1, 5'(10 + k), 32'(32'h100 + k), 5'd10, 5'd12);
        n++;
      end
    end
    idle(4);

    // Register 0 never gets written and is never stored.
    step(0, 1, 5'd0, 32'hDEAD, 1, 5'd0, 32'hBEEF, 0, 0);
    idle(2);

    // Reset during a forced stall with two entries queued.
    step(0, 1, 5'd1, 32'h01, 1, 5'd13, 32'hD13, 5'd13, 5'd14);
    step(0, 1, 5'd1, 32'h01, 1, 5'd14, 32'hD14, 5'd13, 5'd14);
    n = 0;
    while (!m_stall && n < 10) begin
      step(0, 1, 5'd1, 32'h01, 0, 0, 0, 5'd13, 5'd14);
      n++;
    end
    step(1, 1, 5'd1, 32'h01, 0, 0, 0, 5'd13, 5'd14);
    for (int i = 0; i < 3; i++) step(0, 0, 0, 0, 0, 0, 0, 5'd13, 5'd14);

    // Randomised traffic with varying pipe density and occasional reset.
    for (int i = 0; i < 2000; i++) begin
      int dens;
      dens = (i / 250) % 4;
      step(($urandom_range(0, 149) == 0),
           ($urandom_range(0, 3) < dens + 1),
           5'($urandom_range(0, 7)), $urandom,
           ($urandom_range(0, 2) == 0),
           5'($urandom_range(0, 7)), $urandom,
           5'($urandom_range(0, 7)), 5'($urandom_range(0, 7)));
    end
    idle(8);
    @(negedge clk);
    #1;
    chk("write_queue_drained", 32'(exp_wr.size()), 32'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/rf_wr_arbiter.md
Name: rf_wr_arbiter

Overview:
- Arbitrates the single register-file write port between the in-order pipeline writeback path and one long-latency asynchronous result source, such as a multiplier/divider or a late load return.
- Sits between the writeback stage outputs and the register file.
- Buffers async results in a small FIFO and drops async writes made stale by younger pipeline writes.
- Forces a one-cycle pipeline stall when the async source starves, and exposes pending-write lookup for the hazard unit.

Parameters:
- DEPTH, 2: async FIFO entries; power of 2, at least 2.
- STARVE_LIMIT, 4: consecutive blocked cycles of a live FIFO head before a stall is forced; at least 1.

Ports:
- clk  input  1  clock
- reset  input  1  synchronous, active-high reset
- i_pipe_RegWrEn  input  1  writeback stage write request
- i_pipe_RegDst  input  5  writeback destination register
- i_pipe_RegWrData  input  32  writeback data
- i_async_valid  input  1  async result valid
- o_async_ready  output  1  FIFO can accept a result
- i_async_RegDst  input  5  async destination register
- i_async_Data  input  32  async data
- o_RegWrEn  output  1  register-file write enable
- o_RegDst  output  5  register-file write address
- o_RegWrData  output  32  register-file write data
- o_pipe_stall  output  1  registered stall request to the pipeline
- o_pending_cnt  output  $clog2(DEPTH)+1  FIFO occupancy (live and dead entries)
- i_rs1  input  5  hazard lookup, source register 1
- i_rs2  input  5  hazard lookup, source register 2
- o_rs1_pending  output  1  i_rs1 has a live queued write
- o_rs2_pending  output  1  i_rs2 has a live queued write

Behaviour:
- Clock and reset: one clock. Reset is synchronous and active-high.
- Reset contents: reset clears the FIFO, occupancy, the wait counter and o_pipe_stall.
- Outputs while reset is high: o_RegWrEn=0, o_async_ready=0, o_rs*_pending=0, o_pending_cnt=0. No push and no write occur.
- Reset mid-operation: every queued entry is discarded and never written.
- FIFO entry fields: rd[4:0], data[31:0], live.
- Push: i_async_valid & o_async_ready.
  - o_async_ready = (count < DEPTH), taken from registered count only.
  - A full FIFO does not accept a push even in a cycle that pops.
  - The entry is written at the clock edge.
  - It becomes eligible as head on the next cycle; there is no bypass.
- Push with rd=0: accepted and discarded, not stored.
- pipe_act = i_pipe_RegWrEn & (i_pipe_RegDst != 0) & !o_pipe_stall.
- Write-port mux (combinational from current state and inputs):
  - If pipe_act: drive the pipe rd and data, o_RegWrEn=1.
  - Else, if the head is live: drive the head rd and data, o_RegWrEn=1, pop.
  - Else: o_RegWrEn=0. o_RegDst and o_RegWrData are don't-care and drive 0.
- Dead head: pops in any cycle without using the port.
- One pop at most per cycle.
- Kill: when pipe_act, every stored live entry with rd == i_pipe_RegDst is cleared to dead at the edge.
- Kill on same-cycle push: a push in the same cycle with equal rd is stored dead.
- Starvation:
  - blocked = head live & pipe_act.
  - wait_cnt increments while blocked and clears on any cycle the head is granted or the FIFO is empty.
  - o_pipe_stall <= blocked & (wait_cnt == STARVE_LIMIT-1).
  - o_pipe_stall is high for exactly one cycle.
  - While o_pipe_stall is high, the pipe write is suppressed and the head is granted.
  - Next cycle: stall=0 and the held pipe write proceeds.
- Pending lookup: o_rsN_pending = (rsN != 0) & any live stored entry with rd == rsN. Pure combinational over state.
- Occupancy: count is updated by push and pop in the same cycle, giving net 0 when both occur.

Test Plan:
- Pipe idle, push rd=5 data=0xA5 at cycle 0:
  - cycle 1: o_RegWrEn=1, o_RegDst=5, o_RegWrData=0xA5.
  - cycle 2: o_pending_cnt=0.
- Pipe writes rd=3 every cycle, push rd=7 data=0x77 at cycle 0:
  - cycles 1-4: rd=3 written.
  - cycle 5: o_pipe_stall=1 and rd=7/0x77 written.
  - cycle 6: stall=0, rd=3 written.
- Push rd=9 while the pipe is busy, then a pipe write of rd=9 data=0x11:
  - o_rs1_pending (i_rs1=9) drops after the kill edge.
  - rd=9 is never written with the async data.
- DEPTH=2, pipe busy, three back-to-back pushes:
  - o_async_ready=0 after two pushes.
  - The third push is held until a pop, then accepted.
- Push rd=0, and pipe write to rd=0 -> o_RegWrEn stays 0 and occupancy is unchanged.
- Two entries queued, stall asserted, reset high for one cycle:
  - next cycle: o_pending_cnt=0, o_pipe_stall=0, o_async_ready=1.
  - No queued data is ever written.
